// File: rtl/regfile_mp.sv
// -----------------------------------------------------------------------------
// regfile_mp
//   Parametrised multi-port register file with a per-register busy scoreboard.
//   NUM_RD combinational read ports, NUM_WR write ports, one reserve port.
//   The issue stage reserves destination registers (sets busy); the writeback
//   stage writes them, which releases the reservation (clears busy).
//
// Parameters
//   DATA_WIDTH  bits per register
//   REG_COUNT   number of registers (power of two, >= 2)
//   ADDR_WIDTH  register address width
//   NUM_RD      number of read ports
//   NUM_WR      number of write ports
//   ZERO_REG    1: register 0 reads 0, drops writes, is never busy
//
// Ports
//   clk_i        rising-edge clock
//   rst_ni       asynchronous active-low reset
//   we_i         per-port write enable
//   waddr_i      packed write addresses, port p at [p*ADDR_WIDTH +: ADDR_WIDTH]
//   wdata_i      packed write data,      port p at [p*DATA_WIDTH +: DATA_WIDTH]
//   raddr_i      packed read addresses
//   rdata_o      packed read data (combinational)
//   rsv_valid_i  reserve request
//   rsv_addr_i   register to reserve
//   rsv_ready_o  reserve accepted this cycle
//   busy_o       scoreboard, bit r = register r has a write pending
//   wcoll_o      one-cycle pulse after two enabled write ports hit one address
//
// Build option
//   REGFILE_BYPASS_EN  when defined, reads see same-cycle write data and a
//                      reserve may be accepted in the cycle the write releases
//                      the register.
// -----------------------------------------------------------------------------
module regfile_mp #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_COUNT  = 32,
  parameter int ADDR_WIDTH = $clog2(REG_COUNT),
  parameter int NUM_RD     = 2,
  parameter int NUM_WR     = 2,
  parameter int ZERO_REG   = 1
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [NUM_WR-1:0]            we_i,
  input  logic [NUM_WR*ADDR_WIDTH-1:0] waddr_i,
  input  logic [NUM_WR*DATA_WIDTH-1:0] wdata_i,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] raddr_i,
  output logic [NUM_RD*DATA_WIDTH-1:0] rdata_o,
  input  logic                         rsv_valid_i,
  input  logic [ADDR_WIDTH-1:0]        rsv_addr_i,
  output logic                         rsv_ready_o,
  output logic [REG_COUNT-1:0]         busy_o,
  output logic                         wcoll_o
);

  // State
  logic [DATA_WIDTH-1:0] regs_q [REG_COUNT];
  logic [DATA_WIDTH-1:0] regs_d [REG_COUNT];
  logic [REG_COUNT-1:0]  busy_q, busy_d;
  logic                  wcoll_q, wcoll_d;

  // Unpacked, qualified write ports. A write to register 0 in ZERO_REG mode
  // is dropped here so it neither stores, collides nor releases anything.
  logic [NUM_WR-1:0]     wr_act;
  logic [ADDR_WIDTH-1:0] wr_addr [NUM_WR];
  logic [DATA_WIDTH-1:0] wr_data [NUM_WR];

  logic                  rsv_zero;

  always_comb begin
    wr_act = '0;
    for (int p = 0; p < NUM_WR; p++) begin
      wr_addr[p] = waddr_i[p*ADDR_WIDTH +: ADDR_WIDTH];
      wr_data[p] = wdata_i[p*DATA_WIDTH +: DATA_WIDTH];
      wr_act[p]  = we_i[p] && !((ZERO_REG != 0) && (wr_addr[p] == '0));
    end
  end

  // Reserve handshake: a request is offered by holding rsv_valid_i and
  // rsv_addr_i stable; it completes in the cycle rsv_valid_i && rsv_ready_o
  // are both high at the rising edge, and the requester may only change the
  // request after that edge. Ready never depends on anything the requester
  // sees as a consequence of its own request being accepted.
  assign rsv_zero = (ZERO_REG != 0) && (rsv_addr_i == '0);

`ifdef REGFILE_BYPASS_EN
  logic rsv_wr_hit;

  // A register being written this cycle counts as already released.
  always_comb begin
    rsv_wr_hit = 1'b0;
    for (int p = 0; p < NUM_WR; p++) begin
      if (wr_act[p] && (wr_addr[p] == rsv_addr_i)) rsv_wr_hit = 1'b1;
    end
    rsv_ready_o = rsv_valid_i && (rsv_zero || !busy_q[rsv_addr_i] || rsv_wr_hit);
  end
`else
  always_comb begin
    rsv_ready_o = rsv_valid_i && (rsv_zero || !busy_q[rsv_addr_i]);
  end
`endif

  // Next-state: writes in ascending port order so the highest-index port
  // wins an address conflict; busy clears precede the reserve set so a
  // reserve accepted in the same cycle as a write dominates.
  always_comb begin
    regs_d  = regs_q;
    busy_d  = busy_q;
    wcoll_d = 1'b0;
    for (int p = 0; p < NUM_WR; p++) begin
      if (wr_act[p]) begin
        regs_d[wr_addr[p]] = wr_data[p];
        busy_d[wr_addr[p]] = 1'b0;
      end
      for (int q = p + 1; q < NUM_WR; q++) begin
        if (wr_act[p] && wr_act[q] && (wr_addr[p] == wr_addr[q])) wcoll_d = 1'b1;
      end
    end
    if (rsv_ready_o && !rsv_zero) busy_d[rsv_addr_i] = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      regs_q  <= '{default: '0};
      busy_q  <= '0;
      wcoll_q <= 1'b0;
    end else begin
      regs_q  <= regs_d;
      busy_q  <= busy_d;
      wcoll_q <= wcoll_d;
    end
  end

  // Read ports
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] rd_val;

  always_comb begin
    rdata_o = '0;
    rd_addr = '0;
    rd_val  = '0;
    for (int r = 0; r < NUM_RD; r++) begin
      rd_addr = raddr_i[r*ADDR_WIDTH +: ADDR_WIDTH];
      rd_val  = regs_q[rd_addr];
`ifdef REGFILE_BYPASS_EN
      for (int p = 0; p < NUM_WR; p++) begin
        if (wr_act[p] && (wr_addr[p] == rd_addr)) rd_val = wr_data[p];
      end
`endif
      if ((ZERO_REG != 0) && (rd_addr == '0)) rd_val = '0;
      rdata_o[r*DATA_WIDTH +: DATA_WIDTH] = rd_val;
    end
  end

  assign busy_o  = busy_q;
  assign wcoll_o = wcoll_q;

endmodule

// File: tb/tb_regfile_mp.sv
// -----------------------------------------------------------------------------
// tb_regfile_mp
//   Self-checking bench for regfile_mp (default parameters, ZERO_REG=1).
//   A behavioural model (register array, busy vector, collision flag) is
//   updated from the same inputs; a compare process checks every output on
//   each falling edge. Directed scenarios add literal expectations, then a
//   randomized phase exercises writes, collisions and reservations.
// -----------------------------------------------------------------------------
module tb_regfile_mp;
  localparam int DW = 32;
  localparam int RC = 32;
  localparam int AW = 5;
  localparam int NR = 2;
  localparam int NW = 2;

  // Clock / reset
  logic clk;
  logic rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // DUT signals
  logic [NW-1:0]    we;
  logic [NW*AW-1:0] waddr;
  logic [NW*DW-1:0] wdata;
  logic [NR*AW-1:0] raddr;
  logic [NR*DW-1:0] rdata;
  logic             rsv_valid;
  logic [AW-1:0]    rsv_addr;
  logic             rsv_ready;
  logic [RC-1:0]    busy;
  logic             wcoll;

  regfile_mp #(
    .DATA_WIDTH(DW), .REG_COUNT(RC), .ADDR_WIDTH(AW),
    .NUM_RD(NR), .NUM_WR(NW), .ZERO_REG(1)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .we_i(we), .waddr_i(waddr), .wdata_i(wdata),
    .raddr_i(raddr), .rdata_o(rdata),
    .rsv_valid_i(rsv_valid), .rsv_addr_i(rsv_addr), .rsv_ready_o(rsv_ready),
    .busy_o(busy), .wcoll_o(wcoll)
  );

  // Scoreboard counters
  int checks = 0;
  int errors = 0;
  logic cmp_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Behavioural model
  logic [DW-1:0] m_regs [RC];
  logic [RC-1:0] m_busy;
  logic          m_wcoll;

  function automatic logic [AW-1:0] wa(input int p);
    return waddr[p*AW +: AW];
  endfunction

  function automatic logic [DW-1:0] wd(input int p);
    return wdata[p*DW +: DW];
  endfunction

  function automatic logic [DW-1:0] m_read(input logic [AW-1:0] a);
    logic [DW-1:0] v;
    v = m_regs[a];
`ifdef REGFILE_BYPASS_EN
    for (int p = 0; p < NW; p++) if (we[p] && wa(p) == a) v = wd(p);
`endif
    if (a == 0) v = '0;
    return v;
  endfunction

  function automatic logic m_ready();
    logic ok;
    ok = !m_busy[rsv_addr] || (rsv_addr == 0);
`ifdef REGFILE_BYPASS_EN
    for (int p = 0; p < NW; p++) if (we[p] && wa(p) == rsv_addr) ok = 1'b1;
`endif
    return rsv_valid && ok;
  endfunction

  function automatic logic m_coll();
    int cnt [RC];
    logic c;
    c = 1'b0;
    for (int a = 0; a < RC; a++) cnt[a] = 0;
    for (int p = 0; p < NW; p++) if (we[p] && wa(p) != 0) cnt[wa(p)]++;
    for (int a = 0; a < RC; a++) if (cnt[a] >= 2) c = 1'b1;
    return c;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RC; i++) m_regs[i] <= '0;
      m_busy  <= '0;
      m_wcoll <= 1'b0;
    end else begin
      for (int p = 0; p < NW; p++) begin
        if (we[p] && wa(p) != 0) begin
          m_regs[wa(p)] <= wd(p);
          m_busy[wa(p)] <= 1'b0;
        end
      end
      if (m_ready() && rsv_addr != 0) m_busy[rsv_addr] <= 1'b1;
      m_wcoll <= m_coll();
    end
  end

  // Compare process
  always @(negedge clk) begin
    if (rst_n && cmp_en) begin
      for (int r = 0; r < NR; r++)
        chk($sformatf("rdata%0d", r), 64'(rdata[r*DW +: DW]), 64'(m_read(raddr[r*AW +: AW])));
      chk("busy", 64'(busy), 64'(m_busy));
      chk("wcoll", 64'(wcoll), 64'(m_wcoll));
      chk("rsv_ready", 64'(rsv_ready), 64'(m_ready()));
    end
  end

  // Driver tasks
  task automatic idle();
    we = '0; waddr = '0; wdata = '0;
    rsv_valid = 1'b0; rsv_addr = '0;
  endtask

  task automatic set_wr(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d);
    we[p] = 1'b1;
    waddr[p*AW +: AW] = a;
    wdata[p*DW +: DW] = d;
  endtask

  task automatic set_rd(input int r, input logic [AW-1:0] a);
    raddr[r*AW +: AW] = a;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] rd(input int r);
    return rdata[r*DW +: DW];
  endfunction

  // Main sequence
  initial begin
    idle();
    raddr = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", 64'(busy), 64'h0);
    chk("reset_wcoll", 64'(wcoll), 64'h0);
    chk("reset_rdata", 64'(rd(0)), 64'h0);
    rst_n = 1'b1;
    cmp_en = 1'b1;
    tick();

    // Fill: reg i = i+1 alternating write ports, then poke reg 0
    for (int i = 1; i < RC; i++) begin
      idle();
      set_wr(i % 2, AW'(i), DW'(i + 1));
      tick();
    end
    idle();
    set_wr(0, '0, 32'hDEAD);
    tick();
    idle();
    for (int i = 0; i < RC; i++) begin
      set_rd(0, AW'(i));
      set_rd(1, AW'(i));
      #1;
      chk($sformatf("fill_rd0_r%0d", i), 64'(rd(0)), (i == 0) ? 64'h0 : 64'(i + 1));
      chk($sformatf("fill_rd1_r%0d", i), 64'(rd(1)), (i == 0) ? 64'h0 : 64'(i + 1));
    end
    tick();

    // Write collision on r5
    idle();
    set_wr(0, 5'd5, 32'hAAAA);
    set_wr(1, 5'd5, 32'h5555);
    set_rd(0, 5'd5);
    tick();
    idle();
    chk("coll_r5", 64'(rd(0)), 64'h5555);
    chk("coll_pulse", 64'(wcoll), 64'h1);
    tick();
    chk("coll_clear", 64'(wcoll), 64'h0);

    // Scoreboard on r7
    rsv_valid = 1'b1;
    rsv_addr  = 5'd7;
    #1;
    chk("rsv7_ready", 64'(rsv_ready), 64'h1);
    tick();
    chk("rsv7_busy", 64'(busy[7]), 64'h1);
    chk("rsv7_stall", 64'(rsv_ready), 64'h0);
    tick();
    chk("rsv7_stall2", 64'(rsv_ready), 64'h0);
    set_wr(0, 5'd7, 32'h77);
    set_rd(0, 5'd7);
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("rsv7_wr_ready", 64'(rsv_ready), 64'h1);
    tick();
    idle();
    chk("rsv7_reacq", 64'(busy[7]), 64'h1);
    chk("rsv7_data", 64'(rd(0)), 64'h77);
`else
    chk("rsv7_wr_ready", 64'(rsv_ready), 64'h0);
    tick();
    we = '0;
    chk("rsv7_release", 64'(busy[7]), 64'h0);
    chk("rsv7_data", 64'(rd(0)), 64'h77);
    chk("rsv7_held_ready", 64'(rsv_ready), 64'h1);
    tick();
    idle();
    chk("rsv7_reacq", 64'(busy[7]), 64'h1);
`endif

    // Reserve + write on non-busy r9
    rsv_valid = 1'b1;
    rsv_addr  = 5'd9;
    set_wr(1, 5'd9, 32'h99);
    set_rd(0, 5'd9);
    #1;
    chk("rsv9_ready", 64'(rsv_ready), 64'h1);
    tick();
    idle();
    chk("rsv9_data", 64'(rd(0)), 64'h99);
    chk("rsv9_busy", 64'(busy[9]), 64'h1);

    // Reserve of r0 never sets busy
    rsv_valid = 1'b1;
    rsv_addr  = 5'd0;
    #1;
    chk("rsv0_ready", 64'(rsv_ready), 64'h1);
    tick();
    idle();
    chk("rsv0_busy", 64'(busy[0]), 64'h0);
    chk("busy_0x280", 64'(busy), 64'h280);

    // Reset pulse between edges
    set_rd(0, 5'd7);
    set_rd(1, 5'd9);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_wcoll", 64'(wcoll), 64'h0);
    chk("rst_rd0", 64'(rd(0)), 64'h0);
    chk("rst_rd1", 64'(rd(1)), 64'h0);
    #1;
    rst_n = 1'b1;
    tick();

    // Write-to-read visibility on r3
    idle();
    set_wr(0, 5'd3, 32'h1234);
    set_rd(0, 5'd3);
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("byp_same", 64'(rd(0)), 64'h1234);
`else
    chk("byp_same", 64'(rd(0)), 64'h0);
`endif
    tick();
    idle();
    chk("byp_next", 64'(rd(0)), 64'h1234);
    tick();

    // Randomized phase, checked by the compare process
    for (int c = 0; c < 400; c++) begin
      idle();
      for (int p = 0; p < NW; p++) begin
        if ($urandom_range(0, 1) == 1) begin
          set_wr(p, ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, RC - 1))
                                                : AW'($urandom_range(0, 7)),
                 $urandom);
        end
      end
      for (int r = 0; r < NR; r++) set_rd(r, AW'($urandom_range(0, RC - 1)));
      rsv_valid = ($urandom_range(0, 2) != 0);
      rsv_addr  = AW'($urandom_range(0, 7));
      tick();
    end
    idle();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port register file with NUM_RD combinational read ports and NUM_WR write ports.
- Carries a per-register busy scoreboard: a reserve port marks a register as pending, and a write to that register releases it.
- Used as the architectural register store of the pipelined datapath; the issue stage reserves destinations and the writeback stage writes and releases them.
- Optional register-0-hardwired-zero mode; optional write-to-read bypass.

Parameters:
- DATA_WIDTH, 32, bits per register.
- REG_COUNT, 32, number of registers (power of two, >=2).
- ADDR_WIDTH, $clog2(REG_COUNT), register address width.
- NUM_RD, 2, number of read ports (>=1).
- NUM_WR, 2, number of write ports (>=1).
- ZERO_REG, 1, 1 = register 0 always reads 0, ignores writes and is never busy.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- we_i  in  NUM_WR  per-port write enable.
- waddr_i  in  NUM_WR*ADDR_WIDTH  write addresses; port p occupies slice [p*ADDR_WIDTH +: ADDR_WIDTH].
- wdata_i  in  NUM_WR*DATA_WIDTH  write data, packed the same way.
- raddr_i  in  NUM_RD*ADDR_WIDTH  read addresses, packed.
- rdata_o  out  NUM_RD*DATA_WIDTH  read data, packed.
- rsv_valid_i  in  1  reserve request.
- rsv_addr_i  in  ADDR_WIDTH  register to reserve.
- rsv_ready_o  out  1  reserve accepted this cycle.
- busy_o  out  REG_COUNT  scoreboard; bit r = register r has a write pending.
- wcoll_o  out  1  one-cycle pulse: two or more enabled write ports hit the same address.

Behaviour:
- Reset:
  - Clock and reset are a single clock with asynchronous, active-low reset (clk_i, rst_ni).
  - On rst_ni=0, immediately and asynchronously: all registers=0, busy_o=0, wcoll_o=0.
  - Reset mid-operation discards all pending reservations.
- Reads:
  - Combinational: rdata_o[p] = reg[raddr_i[p]] as of the last clock edge.
  - ZERO_REG=1 and address 0 -> reads 0.
  - Any number of ports may read the same address.
- Writes:
  - On the rising edge, each port p with we_i[p]=1 writes wdata_i[p] to reg[waddr_i[p]].
  - Same-address conflict: the highest-index enabled port wins, and wcoll_o=1 for the following cycle only.
  - ZERO_REG=1: writes to address 0 are dropped and do not count toward wcoll_o.
- Scoreboard:
  - A write to register r clears busy_o[r] at the edge.
  - Writing a non-busy register is legal; data is stored and busy stays 0.
- Reserve handshake:
  - rsv_ready_o = rsv_valid_i & ~busy_o[rsv_addr_i], combinational.
  - ZERO_REG=1 and rsv_addr_i=0: always ready; no busy bit is set.
  - On valid & ready: busy_o[rsv_addr_i] is set at the edge.
  - Reserving an already-busy register stalls (ready=0) with no state change; the requester holds valid and addr until ready.
  - Same-cycle reserve and write to the same, currently busy register: ready=0 that cycle; the write clears busy, and the reserve is accepted next cycle.
  - Same-cycle reserve and write to the same, currently non-busy register: reserve is accepted, write stores data, final busy=1 (set dominates clear).
- Latency:
  - Write to read-visible: 1 cycle.
  - Write to busy release: 1 cycle.
  - Reserve to busy_o set: 1 cycle.

Optional Feature:
- Macro REGFILE_BYPASS_EN.
- Defined: if any enabled write port targets raddr_i[p] in the current cycle, rdata_o[p] returns that port's wdata_i combinationally, using the highest-index match (ZERO_REG rules still apply). rsv_ready_o also treats a register being written this cycle as not busy, so a reserve can be accepted in the same cycle the write releases it.
- Undefined: reads return stored data only; reservations follow the base rules above.

Test Plan:
- Fill and read: write reg i = i+1 for i=1..31 using both ports alternately, then read all registers on both read ports. Required: rdata = i+1; reg 0 reads 0 even after writing 0xDEAD to it.
- Write collision: we_i=2'b11, both waddr=5, wdata0=0xAAAA, wdata1=0x5555. Required: next cycle reg5 reads 0x5555 and wcoll_o=1 for exactly one cycle.
- Scoreboard: reserve r7 -> busy_o[7]=1 the next cycle. A second reserve of r7 gets rsv_ready_o=0. Writing 0x77 to r7 -> busy_o[7]=0 and r7 reads 0x77. The held reserve is then accepted.
- Simultaneous reserve and write on non-busy r9: reserve accepted, r9 = written value, busy_o[9]=1. Reserve of r0 with ZERO_REG=1: ready=1, busy_o[0] stays 0.
- Reset mid-operation: with busy_o=0x0000_0280 and registers non-zero, pulse rst_ni low between clock edges. Required: busy_o=0, all reads return 0, wcoll_o=0, all before the next clock edge.
- Bypass, with REGFILE_BYPASS_EN defined: write 0x1234 to r3 while raddr_i[0]=3. Required: rdata_o[0]=0x1234 in the same cycle. Without the macro, rdata_o[0] shows the old value that cycle and 0x1234 the cycle after.
